// File: rtl/wb_rr_arbiter_pkg.sv
// Shared definitions for the Wishbone round-robin arbiter: CTI codes and FSM state encodings.
package wb_rr_arbiter_pkg;

  typedef logic [2:0] wb_cti_t;

  localparam wb_cti_t WB_CTI_CLASSIC = 3'b000;
  localparam wb_cti_t WB_CTI_INCR    = 3'b010;
  localparam wb_cti_t WB_CTI_END     = 3'b111;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t ST_IDLE  = 2'd0;
  localparam arb_state_t ST_BUSY  = 2'd1;
  localparam arb_state_t ST_ABORT = 2'd2;

endpackage

// File: rtl/wb_rr_arbiter_if.sv
// Bus bundle for the arbiter: the packed master-side request ports and the single slave port.
// The "slave" modport is the face the arbiter shows to the masters, "master" the face it shows
// to the shared slave.
interface wb_rr_arbiter_if #(parameter int NMASTERS = 4);
  import wb_rr_arbiter_pkg::*;

  logic [NMASTERS*32-1:0] m_adr_i;
  logic [NMASTERS*32-1:0] m_dat_i;
  logic [31:0]            m_dat_o;
  logic [NMASTERS*4-1:0]  m_sel_i;
  logic [NMASTERS*3-1:0]  m_cti_i;
  logic [NMASTERS-1:0]    m_we_i;
  logic [NMASTERS-1:0]    m_cyc_i;
  logic [NMASTERS-1:0]    m_stb_i;
  logic [NMASTERS-1:0]    m_ack_o;
  logic [NMASTERS-1:0]    m_err_o;

  logic [31:0]            s_adr_o;
  logic [31:0]            s_dat_o;
  logic [3:0]             s_sel_o;
  wb_cti_t                s_cti_o;
  logic                   s_we_o;
  logic                   s_cyc_o;
  logic                   s_stb_o;
  logic [31:0]            s_dat_i;
  logic                   s_ack_i;

  modport slave (
    input  m_adr_i, m_dat_i, m_sel_i, m_cti_i, m_we_i, m_cyc_i, m_stb_i,
    output m_dat_o, m_ack_o, m_err_o
  );

  modport master (
    output s_adr_o, s_dat_o, s_sel_o, s_cti_o, s_we_o, s_cyc_o, s_stb_o,
    input  s_dat_i, s_ack_i
  );

endinterface

// File: rtl/wb_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible requester at or after ptr, wrapping around.
module wb_rr_arbiter_rr_pick
  import wb_rr_arbiter_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  input  logic [N-1:0]  mask,
  output logic [N-1:0]  grant,
  output logic          valid
);

  logic [N-1:0] elig;

  assign elig = req & mask;

  // Scan ptr..N-1 first, then wrap and scan 0..ptr-1; the first hit wins
  always_comb begin
    grant = '0;
    valid = 1'b0;
    for (int j = 0; j < N; j++) begin
      if (!valid && elig[j] && (PW'(j) >= ptr)) begin
        grant[j] = 1'b1;
        valid    = 1'b1;
      end
    end
    for (int j = 0; j < N; j++) begin
      if (!valid && elig[j]) begin
        grant[j] = 1'b1;
        valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin arbiter sharing one Wishbone slave among NMASTERS masters, with a stall watchdog.
// A grant is held for the whole bus cycle (bursts included) until the granted master drops cyc.
module wb_rr_arbiter
  import wb_rr_arbiter_pkg::*;
#(
  parameter int NMASTERS = 4,
  parameter int TIMEOUT  = 1024
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  wb_rr_arbiter_if.slave      m_bus,
  wb_rr_arbiter_if.master     s_bus,
  output logic [NMASTERS-1:0] grant_o,
  output logic                timeout_irq
);

  localparam int PW = $clog2(NMASTERS);
  localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WW-1:0] WD_LAST = (TIMEOUT > 0) ? WW'(TIMEOUT - 1) : '0;
  localparam logic [WW-1:0] WD_MAX  = WW'(TIMEOUT);
  localparam bit WD_EN = (TIMEOUT > 0);

  arb_state_t          state;
  logic [NMASTERS-1:0] grant;
  logic [PW-1:0]       ptr;
  logic [WW-1:0]       wdog;

  logic [PW-1:0]       g_idx;
  logic [PW-1:0]       next_ptr;
  logic                busy;
  logic                g_cyc;
  logic                g_stb;
  logic                s_cyc;
  logic                s_stb;
  logic                stall;
  logic [PW-1:0]       pick_ptr;
  logic [NMASTERS-1:0] pick_mask;
  logic [NMASTERS-1:0] pick_grant;
  logic                pick_valid;

  logic [31:0]         mux_adr;
  logic [31:0]         mux_dat;
  logic [3:0]          mux_sel;
  wb_cti_t             mux_cti;
  logic                mux_we;

  // Turn the one-hot grant into an index so the pointer can advance past the owner
  always_comb begin
    g_idx = '0;
    for (int k = 0; k < NMASTERS; k++) begin
      if (grant[k]) g_idx = PW'(k);
    end
  end

  assign next_ptr = (g_idx == PW'(NMASTERS - 1)) ? '0 : g_idx + PW'(1);

  assign busy  = (state == ST_BUSY);
  assign g_cyc = |(m_bus.m_cyc_i & grant);
  assign g_stb = |(m_bus.m_stb_i & grant);
  assign s_cyc = busy & g_cyc;
  assign s_stb = busy & g_cyc & g_stb;
  assign stall = s_stb & ~s_bus.s_ack_i;

  // On release the search starts after the old owner and skips it; from IDLE it uses the pointer
  always_comb begin
    pick_ptr  = ptr;
    pick_mask = '1;
    if (busy) begin
      pick_ptr  = next_ptr;
      pick_mask = ~grant;
    end
  end

  wb_rr_arbiter_rr_pick #(
    .N  (NMASTERS),
    .PW (PW)
  ) u_pick (
    .req   (m_bus.m_cyc_i),
    .ptr   (pick_ptr),
    .mask  (pick_mask),
    .grant (pick_grant),
    .valid (pick_valid)
  );

  // Route the granted master's request fields to the slave; nothing is driven without a grant
  always_comb begin
    mux_adr = '0;
    mux_dat = '0;
    mux_sel = '0;
    mux_cti = WB_CTI_CLASSIC;
    mux_we  = 1'b0;
    for (int k = 0; k < NMASTERS; k++) begin
      if (grant[k]) begin
        mux_adr = m_bus.m_adr_i[32*k +: 32];
        mux_dat = m_bus.m_dat_i[32*k +: 32];
        mux_sel = m_bus.m_sel_i[4*k +: 4];
        mux_cti = m_bus.m_cti_i[3*k +: 3];
        mux_we  = m_bus.m_we_i[k];
      end
    end
  end

  assign s_bus.s_adr_o = mux_adr;
  assign s_bus.s_dat_o = mux_dat;
  assign s_bus.s_sel_o = mux_sel;
  assign s_bus.s_cti_o = mux_cti;
  assign s_bus.s_we_o  = mux_we;
  assign s_bus.s_cyc_o = s_cyc;
  assign s_bus.s_stb_o = s_stb;

  assign m_bus.m_dat_o = s_bus.s_dat_i;
  assign m_bus.m_ack_o = {NMASTERS{busy & s_bus.s_ack_i}} & grant;
  assign m_bus.m_err_o = {NMASTERS{state == ST_ABORT}} & grant;
  assign timeout_irq   = (state == ST_ABORT);
  assign grant_o       = grant;

  // Arbitration FSM: grant from IDLE, hand over or release from BUSY, one-cycle ABORT on stall
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state <= ST_IDLE;
      grant <= '0;
      ptr   <= '0;
      wdog  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          wdog <= '0;
          if (pick_valid) begin
            grant <= pick_grant;
            state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (!g_cyc) begin
            ptr  <= next_ptr;
            wdog <= '0;
            if (pick_valid) begin
              grant <= pick_grant;
            end else begin
              grant <= '0;
              state <= ST_IDLE;
            end
          end else if (stall) begin
            if (WD_EN && (wdog == WD_LAST)) state <= ST_ABORT;
            if (wdog != WD_MAX) wdog <= wdog + WW'(1);
          end else begin
            wdog <= '0;
          end
        end
        ST_ABORT: begin
          grant <= '0;
          ptr   <= next_ptr;
          wdog  <= '0;
          state <= ST_IDLE;
        end
        default: begin
          grant <= '0;
          wdog  <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Self-checking bench for wb_rr_arbiter: a vector table for rotation and single transfers,
// plus hand-written sequences for burst hold, watchdog abort, late ack and reset mid-burst.
module tb_wb_rr_arbiter;
  import wb_rr_arbiter_pkg::*;

  localparam int NM = 4;
  localparam int TO = 16;

  logic          sys_clk;
  logic          sys_rst;
  logic [NM-1:0] grant_o;
  logic          timeout_irq;

  int checks = 0;
  int errors = 0;

  wb_rr_arbiter_if #(.NMASTERS(NM)) bus ();

  wb_rr_arbiter #(
    .NMASTERS (NM),
    .TIMEOUT  (TO)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .m_bus       (bus),
    .s_bus       (bus),
    .grant_o     (grant_o),
    .timeout_irq (timeout_irq)
  );

  // 10 ns clock, rising edges at 5, 15, 25, ...
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [3:0]  cyc;
    logic [3:0]  stb;
    logic        ack;
    logic [31:0] dat;
    logic [2:0]  cti1;
    logic [3:0]  e_grant;
    logic        e_cyc;
    logic        e_stb;
    logic [3:0]  e_ack;
    logic [3:0]  e_err;
    logic        e_irq;
  } vec_t;

  vec_t vecs [16];

  function automatic vec_t mkVec(input logic [3:0] cyc, input logic [3:0] stb, input logic ack,
                                 input logic [31:0] dat, input logic [2:0] cti1,
                                 input logic [3:0] e_grant, input logic e_cyc, input logic e_stb,
                                 input logic [3:0] e_ack, input logic [3:0] e_err, input logic e_irq);
    vec_t v;
    v.cyc = cyc; v.stb = stb; v.ack = ack; v.dat = dat; v.cti1 = cti1;
    v.e_grant = e_grant; v.e_cyc = e_cyc; v.e_stb = e_stb;
    v.e_ack = e_ack; v.e_err = e_err; v.e_irq = e_irq;
    return v;
  endfunction

  function automatic logic [31:0] adrOf(input int k);
    return 32'h4000_0000 | (32'(k) << 8);
  endfunction

  function automatic logic [31:0] datOf(input int k);
    return 32'hD000_0000 | 32'(k);
  endfunction

  function automatic logic [31:0] expAdr(input logic [3:0] g);
    logic [31:0] r;
    r = '0;
    for (int k = 0; k < NM; k++) if (g[k]) r = adrOf(k);
    return r;
  endfunction

  function automatic logic [31:0] expDat(input logic [3:0] g);
    logic [31:0] r;
    r = '0;
    for (int k = 0; k < NM; k++) if (g[k]) r = datOf(k);
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs just after the rising edge
  task automatic applyStimulus(input vec_t v);
    @(posedge sys_clk);
    #1;
    bus.m_cyc_i = v.cyc;
    bus.m_stb_i = v.stb;
    bus.s_ack_i = v.ack;
    bus.s_dat_i = v.dat;
    bus.m_cti_i = {WB_CTI_CLASSIC, WB_CTI_CLASSIC, v.cti1, WB_CTI_CLASSIC};
  endtask

  // Apply a vector and compare every observable output on the falling edge of the same cycle
  task automatic stepCheck(input string tag, input vec_t v);
    applyStimulus(v);
    @(negedge sys_clk);
    checkOutput({tag, " grant"}, 32'(grant_o), 32'(v.e_grant));
    checkOutput({tag, " s_cyc"}, 32'(bus.s_cyc_o), 32'(v.e_cyc));
    checkOutput({tag, " s_stb"}, 32'(bus.s_stb_o), 32'(v.e_stb));
    checkOutput({tag, " m_ack"}, 32'(bus.m_ack_o), 32'(v.e_ack));
    checkOutput({tag, " m_err"}, 32'(bus.m_err_o), 32'(v.e_err));
    checkOutput({tag, " irq"}, 32'(timeout_irq), 32'(v.e_irq));
    checkOutput({tag, " m_dat"}, bus.m_dat_o, v.dat);
    checkOutput({tag, " s_adr"}, bus.s_adr_o, expAdr(v.e_grant));
    checkOutput({tag, " s_dat"}, bus.s_dat_o, expDat(v.e_grant));
    checkOutput({tag, " s_cti"}, 32'(bus.s_cti_o), v.e_grant[1] ? 32'(v.cti1) : 32'(WB_CTI_CLASSIC));
  endtask

  initial begin
    sys_rst     = 1'b1;
    bus.m_cyc_i = '0;
    bus.m_stb_i = '0;
    bus.m_cti_i = '0;
    bus.s_ack_i = 1'b0;
    bus.s_dat_i = '0;
    bus.m_adr_i = {adrOf(3), adrOf(2), adrOf(1), adrOf(0)};
    bus.m_dat_i = {datOf(3), datOf(2), datOf(1), datOf(0)};
    bus.m_sel_i = 16'h8421;
    bus.m_we_i  = 4'b1010;

    // Contention from reset (rotation 0,1,2,3 then 0 again), then a single transfer by master 0
    vecs[0]  = mkVec(4'b1111, 4'b1111, 1'b0, 32'h0,         3'b000, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0, 1'b0);
    vecs[1]  = mkVec(4'b1111, 4'b1111, 1'b1, 32'hA0A0_0000, 3'b000, 4'b0001, 1'b1, 1'b1, 4'b0001, 4'b0, 1'b0);
    vecs[2]  = mkVec(4'b1110, 4'b1110, 1'b0, 32'h0,         3'b000, 4'b0001, 1'b0, 1'b0, 4'b0000, 4'b0, 1'b0);
    vecs[3]  = mkVec(4'b1110, 4'b1110, 1'b1, 32'hA1A1_0001, 3'b000, 4'b0010, 1'b1, 1'b1, 4'b0010, 4'b0, 1'b0);
    vecs[4]  = mkVec(4'b1100, 4'b1100, 1'b0, 32'h0,         3'b000, 4'b0010, 1'b0, 1'b0, 4'b0000, 4'b0, 1'b0);
    vecs[5]  = mkVec(4'b1100, 4'b1100, 1'b1, 32'hA2A2_0002, 3'b000, 4'b0100, 1'b1, 1'b1, 4'b0100, 4'b0, 1'b0);
    vecs[6]  = mkVec(4'b1001, 4'b1001, 1'b0, 32'h0,         3'b000, 4'b0100, 1'b0, 1'b0, 4'b0000, 4'b0, 1'b0);
    vecs[7]  = mkVec(4'b1001, 4'b1001, 1'b1, 32'hA3A3_0003, 3'b000, 4'b1000, 1'b1, 1'b1, 4'b1000, 4'b0, 1'b0);
    vecs[8]  = mkVec(4'b0001, 4'b0001, 1'b0, 32'h0,         3'b000, 4'b1000, 1'b0, 1'b0, 4'b0000, 4'b0, 1'b0);
    vecs[9]  = mkVec(4'b0001, 4'b0001, 1'b1, 32'hA0A0_0004, 3'b000, 4'b0001, 1'b1, 1'b1, 4'b0001, 4'b0, 1'b0);
    vecs[10] = mkVec(4'b0000, 4'b0000, 1'b0, 32'h0,         3'b000, 4'b0001, 1'b0, 1'b0, 4'b0000, 4'b0, 1'b0);
    vecs[11] = mkVec(4'b0000, 4'b0000, 1'b0, 32'h0,         3'b000, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0, 1'b0);
    vecs[12] = mkVec(4'b0001, 4'b0001, 1'b0, 32'h0,         3'b000, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0, 1'b0);
    vecs[13] = mkVec(4'b0001, 4'b0001, 1'b1, 32'hDEADBEEF,  3'b000, 4'b0001, 1'b1, 1'b1, 4'b0001, 4'b0, 1'b0);
    vecs[14] = mkVec(4'b0000, 4'b0000, 1'b0, 32'h0,         3'b000, 4'b0001, 1'b0, 1'b0, 4'b0000, 4'b0, 1'b0);
    vecs[15] = mkVec(4'b0000, 4'b0000, 1'b0, 32'h0,         3'b000, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0, 1'b0);

    // Reset state
    @(negedge sys_clk);
    checkOutput("reset grant", 32'(grant_o), 32'h0);
    checkOutput("reset s_cyc", 32'(bus.s_cyc_o), 32'h0);
    checkOutput("reset s_stb", 32'(bus.s_stb_o), 32'h0);
    checkOutput("reset m_ack", 32'(bus.m_ack_o), 32'h0);
    checkOutput("reset m_err", 32'(bus.m_err_o), 32'h0);
    checkOutput("reset irq", 32'(timeout_irq), 32'h0);
    checkOutput("reset s_adr", bus.s_adr_o, 32'h0);
    sys_rst = 1'b0;

    $display("[TB] vector table");
    for (int i = 0; i < 16; i++) stepCheck($sformatf("vec%0d", i), vecs[i]);

    // Burst hold: master 1 bursts INCR x3 then END while master 2 waits; pointer is 1 here
    $display("[TB] burst hold");
    stepCheck("burst0", mkVec(4'b0010, 4'b0010, 1'b0, 32'h0,  WB_CTI_INCR, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0, 1'b0));
    stepCheck("burst1", mkVec(4'b0110, 4'b0110, 1'b1, 32'h11, WB_CTI_INCR, 4'b0010, 1'b1, 1'b1, 4'b0010, 4'b0, 1'b0));
    stepCheck("burst2", mkVec(4'b0110, 4'b0110, 1'b1, 32'h22, WB_CTI_INCR, 4'b0010, 1'b1, 1'b1, 4'b0010, 4'b0, 1'b0));
    stepCheck("burst3", mkVec(4'b0110, 4'b0100, 1'b0, 32'h0,  WB_CTI_INCR, 4'b0010, 1'b1, 1'b0, 4'b0000, 4'b0, 1'b0));
    stepCheck("burst4", mkVec(4'b0110, 4'b0110, 1'b1, 32'h33, WB_CTI_INCR, 4'b0010, 1'b1, 1'b1, 4'b0010, 4'b0, 1'b0));
    stepCheck("burst5", mkVec(4'b0110, 4'b0110, 1'b1, 32'h44, WB_CTI_END,  4'b0010, 1'b1, 1'b1, 4'b0010, 4'b0, 1'b0));
    stepCheck("burst6", mkVec(4'b0100, 4'b0100, 1'b0, 32'h0,  WB_CTI_CLASSIC, 4'b0010, 1'b0, 1'b0, 4'b0000, 4'b0, 1'b0));
    stepCheck("burst7", mkVec(4'b0100, 4'b0100, 1'b1, 32'h55, WB_CTI_CLASSIC, 4'b0100, 1'b1, 1'b1, 4'b0100, 4'b0, 1'b0));
    stepCheck("burst8", mkVec(4'b0000, 4'b0000, 1'b0, 32'h0,  WB_CTI_CLASSIC, 4'b0100, 1'b0, 1'b0, 4'b0000, 4'b0, 1'b0));
    stepCheck("burst9", mkVec(4'b0000, 4'b0000, 1'b0, 32'h0,  WB_CTI_CLASSIC, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0, 1'b0));

    // Watchdog: master 0 stalls for TIMEOUT cycles, then one ABORT cycle with a late ack
    $display("[TB] watchdog");
    stepCheck("wd_req", mkVec(4'b0001, 4'b0001, 1'b0, 32'h0, 3'b000, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0, 1'b0));
    for (int k = 0; k < TO; k++)
      stepCheck($sformatf("wd_stall%0d", k),
                mkVec(4'b0001, 4'b0001, 1'b0, 32'h0, 3'b000, 4'b0001, 1'b1, 1'b1, 4'b0000, 4'b0, 1'b0));
    stepCheck("wd_abort", mkVec(4'b0001, 4'b0001, 1'b1, 32'h1234, 3'b000, 4'b0001, 1'b0, 1'b0, 4'b0000, 4'b0001, 1'b1));
    stepCheck("wd_idle",  mkVec(4'b0000, 4'b0000, 1'b0, 32'h0, 3'b000, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0, 1'b0));

    // After the abort the pointer sits at 1; master 2 then gets a normal transfer
    stepCheck("after0", mkVec(4'b0100, 4'b0100, 1'b0, 32'h0,         3'b000, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0, 1'b0));
    stepCheck("after1", mkVec(4'b0100, 4'b0100, 1'b1, 32'hCAFE_F00D, 3'b000, 4'b0100, 1'b1, 1'b1, 4'b0100, 4'b0, 1'b0));
    stepCheck("after2", mkVec(4'b0000, 4'b0000, 1'b0, 32'h0,         3'b000, 4'b0100, 1'b0, 1'b0, 4'b0000, 4'b0, 1'b0));
    stepCheck("after3", mkVec(4'b0000, 4'b0000, 1'b0, 32'h0,         3'b000, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0, 1'b0));

    // Reset mid-burst: outputs drop between edges, then arbitration restarts at master 0
    $display("[TB] reset mid-burst");
    stepCheck("rst0", mkVec(4'b0010, 4'b0010, 1'b0, 32'h0,  WB_CTI_INCR, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0, 1'b0));
    stepCheck("rst1", mkVec(4'b0010, 4'b0010, 1'b1, 32'h77, WB_CTI_INCR, 4'b0010, 1'b1, 1'b1, 4'b0010, 4'b0, 1'b0));
    #2;
    sys_rst = 1'b1;
    #1;
    checkOutput("rst_mid grant", 32'(grant_o), 32'h0);
    checkOutput("rst_mid s_cyc", 32'(bus.s_cyc_o), 32'h0);
    checkOutput("rst_mid s_stb", 32'(bus.s_stb_o), 32'h0);
    checkOutput("rst_mid m_ack", 32'(bus.m_ack_o), 32'h0);
    checkOutput("rst_mid m_err", 32'(bus.m_err_o), 32'h0);
    checkOutput("rst_mid s_adr", bus.s_adr_o, 32'h0);
    bus.m_cyc_i = 4'b1111;
    bus.m_stb_i = 4'b1111;
    bus.s_ack_i = 1'b0;
    bus.m_cti_i = '0;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    stepCheck("rst2", mkVec(4'b1111, 4'b1111, 1'b1, 32'h5555_AAAA, 3'b000, 4'b0001, 1'b1, 1'b1, 4'b0001, 4'b0, 1'b0));
    stepCheck("rst3", mkVec(4'b0000, 4'b0000, 1'b0, 32'h0,         3'b000, 4'b0001, 1'b0, 1'b0, 4'b0000, 4'b0, 1'b0));
    stepCheck("rst4", mkVec(4'b0000, 4'b0000, 1'b0, 32'h0,         3'b000, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0, 1'b0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
